// File: rtl/slave_mem_pkg.sv
// Shared types and constants for the slave_mem memory model:
// FSM state encoding, LFSR feedback polynomial and default seed.
package slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_POLY    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h5A;

    // An all-zero seed would lock the LFSR up, so it is replaced by 1
    function automatic logic [7:0] fix_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/slave_mem_lfsr8.sv
// 8-bit Galois LFSR with enable; loads the (zero-protected) seed on reset.
module lfsr8
    import slave_mem_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic [7:0] state
);

    logic [7:0] state_reg;
    logic [7:0] state_next;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_tap
            if (gi == 7) begin : g_msb
                assign state_next[gi] = LFSR_POLY[gi] & state_reg[0];
            end else begin : g_low
                assign state_next[gi] = state_reg[gi+1] ^ (LFSR_POLY[gi] & state_reg[0]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= fix_seed(SEED);
        end else if (enable) begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/slave_mem.sv
// Crossbar slave memory model: 2**ADDR_W x 32 RAM behind a Moore FSM that
// inserts fixed or LFSR-driven wait states before acknowledging each request.
module slave_mem
    import slave_mem_pkg::*;
#(
    parameter logic [7:0] SEED       = DEFAULT_SEED,
    parameter bit         RAND_WAIT  = 1'b1,
    parameter int         FIXED_WAIT = 2,
    parameter logic [3:0] WAIT_MASK  = 4'h3,
    parameter int         ADDR_W     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        slave_req,
    input  logic [31:0] slave_addr,
    input  logic        slave_cmd,
    input  logic [31:0] slave_wdata,
    output logic        slave_ack,
    output logic [31:0] slave_rdata,
    output logic        slave_resp,
    output logic [15:0] trans_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              state_reg;
    state_t              state_next;
    logic [3:0]          wait_cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                cmd_reg;
    logic [31:0]         wdata_reg;
    logic                ack_reg;
    logic                resp_reg;
    logic [31:0]         rdata_reg;
    logic [15:0]         trans_cnt_reg;

    logic [7:0]          lfsr_state;
    logic                accept;
    logic [3:0]          wait_load;
    logic                commit;
    logic                mem_we;
    logic                unused_addr_bits;

    // Contents survive reset; only the power-on value is zero
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    assign unused_addr_bits = ^slave_addr[31:ADDR_W];

    assign accept    = (state_reg == IDLE) && slave_req;
    assign wait_load = RAND_WAIT ? (lfsr_state[3:0] & WAIT_MASK) : 4'(FIXED_WAIT);
    assign mem_we    = (state_reg == ACK) && cmd_reg;
    assign commit    = mem_we || (state_reg == RESP);

    lfsr8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (accept),
        .state   (lfsr_state)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (slave_req) state_next = WAIT;
            WAIT: begin
                if (!slave_req) begin
                    state_next = IDLE;
                end else if (wait_cnt_reg == 4'd0) begin
                    state_next = ACK;
                end
            end
            ACK:     state_next = cmd_reg ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 4'd0;
            addr_reg      <= '0;
            cmd_reg       <= 1'b0;
            wdata_reg     <= 32'h0;
            ack_reg       <= 1'b0;
            resp_reg      <= 1'b0;
            rdata_reg     <= 32'h0;
            trans_cnt_reg <= 16'h0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= (state_next == ACK);
            resp_reg  <= (state_next == RESP);
            case (state_reg)
                IDLE: begin
                    if (slave_req) begin
                        addr_reg     <= slave_addr[ADDR_W-1:0];
                        cmd_reg      <= slave_cmd;
                        wdata_reg    <= slave_wdata;
                        wait_cnt_reg <= wait_load;
                    end
                end
                WAIT: begin
                    if (slave_req && (wait_cnt_reg != 4'd0)) begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                ACK: begin
                    if (!cmd_reg) begin
                        rdata_reg <= mem[addr_reg];
                    end
                end
                default: ;
            endcase
            if (commit && (trans_cnt_reg != 16'hFFFF)) begin
                trans_cnt_reg <= trans_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    assign slave_ack   = ack_reg;
    assign slave_resp  = resp_reg;
    assign slave_rdata = rdata_reg;
    assign trans_cnt   = trans_cnt_reg;

endmodule

// File: tb/tb_slave_mem.sv
// Directed bench: fixed-wait instance (a_*) for protocol/latency/reset checks,
// random-wait instance (b_*) for 100 back-to-back held writes.
module tb_slave_mem;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_req, a_cmd;
    logic [31:0] a_addr, a_wdata;
    logic        a_ack, a_resp;
    logic [31:0] a_rdata;
    logic [15:0] a_cnt;

    logic        b_req, b_cmd;
    logic [31:0] b_addr, b_wdata;
    logic        b_ack, b_resp;
    logic [31:0] b_rdata;
    logic [15:0] b_cnt;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    slave_mem #(
        .SEED(8'h5A), .RAND_WAIT(1'b0), .FIXED_WAIT(2), .WAIT_MASK(4'h3), .ADDR_W(8)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .slave_req(a_req), .slave_addr(a_addr), .slave_cmd(a_cmd), .slave_wdata(a_wdata),
        .slave_ack(a_ack), .slave_rdata(a_rdata), .slave_resp(a_resp), .trans_cnt(a_cnt)
    );

    slave_mem #(
        .SEED(8'h5A), .RAND_WAIT(1'b1), .FIXED_WAIT(2), .WAIT_MASK(4'h3), .ADDR_W(8)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .slave_req(b_req), .slave_addr(b_addr), .slave_cmd(b_cmd), .slave_wdata(b_wdata),
        .slave_ack(b_ack), .slave_rdata(b_rdata), .slave_resp(b_resp), .trans_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request before edge 1 and return the edge number after which ack was seen
    task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d, output int lat);
        a_req   = 1'b1;
        a_cmd   = c;
        a_addr  = a;
        a_wdata = d;
        lat     = 0;
        do begin
            tick();
            lat++;
            a_wdata = ~d;
        end while (a_ack !== 1'b1 && lat < 20);
        a_req = 1'b0;
        $display("txn cmd=%0d addr=%h wdata=%h ack_edge=%0d", c, a, d, lat);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic [7:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 8'hB8;
        return n;
    endfunction

    initial begin
        int          lat;
        int          edge_n, prev_ack, acks, resp_seen;
        logic [7:0]  lf;
        logic [3:0]  w;

        reset_n = 1'b0;
        a_req = 1'b0; a_cmd = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_cmd = 1'b1; b_addr = 32'h40; b_wdata = 32'h0BAD_F00D;
        #1;
        check("rst_ack",   {31'h0, a_ack},  32'h0);
        check("rst_resp",  {31'h0, a_resp}, 32'h0);
        check("rst_rdata", a_rdata,         32'h0);
        check("rst_cnt",   {16'h0, a_cnt},  32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // write 0x10 <- 0x1234
        txn(1'b1, 32'h10, 32'h1234, lat);
        check("wr1_lat",  lat, 4);
        check("wr1_resp", {31'h0, a_resp}, 32'h0);
        tick();
        check("wr1_ack_1cyc", {31'h0, a_ack}, 32'h0);
        check("wr1_cnt",  {16'h0, a_cnt}, 32'd1);

        // read 0x10
        txn(1'b0, 32'h10, 32'h0, lat);
        check("rd1_lat", lat, 4);
        tick();
        check("rd1_resp",  {31'h0, a_resp}, 32'h1);
        check("rd1_ack",   {31'h0, a_ack},  32'h0);
        check("rd1_rdata", a_rdata, 32'h1234);
        check("rd1_cnt_pre", {16'h0, a_cnt}, 32'd1);
        tick();
        check("rd1_resp_1cyc", {31'h0, a_resp}, 32'h0);
        check("rd1_cnt",  {16'h0, a_cnt}, 32'd2);
        check("rd1_hold", a_rdata, 32'h1234);

        // upper address bits ignored
        txn(1'b1, 32'hC000_0010, 32'hAAAA, lat);
        check("wr2_lat", lat, 4);
        tick();
        check("wr2_cnt", {16'h0, a_cnt}, 32'd3);
        txn(1'b0, 32'h10, 32'h0, lat);
        tick();
        check("rd2_rdata", a_rdata, 32'hAAAA);
        tick();
        check("rd2_cnt", {16'h0, a_cnt}, 32'd4);

        // never-written location reads as zero
        txn(1'b0, 32'hFF, 32'h0, lat);
        tick();
        check("rd_init_rdata", a_rdata, 32'h0);
        tick();
        check("rd_init_cnt", {16'h0, a_cnt}, 32'd5);

        // read aborted after one WAIT cycle, then a fresh write
        a_req = 1'b1; a_cmd = 1'b0; a_addr = 32'h10;
        tick();
        tick();
        a_req = 1'b0;
        tick();
        check("abort_ack",  {31'h0, a_ack},  32'h0);
        check("abort_resp", {31'h0, a_resp}, 32'h0);
        check("abort_cnt",  {16'h0, a_cnt},  32'd5);
        $display("abort read addr=00000010");
        txn(1'b1, 32'h20, 32'h5555, lat);
        check("post_abort_lat", lat, 4);
        tick();
        check("post_abort_cnt", {16'h0, a_cnt}, 32'd6);
        txn(1'b0, 32'h20, 32'h0, lat);
        tick();
        check("rd3_rdata", a_rdata, 32'h5555);
        tick();
        check("rd3_cnt", {16'h0, a_cnt}, 32'd7);

        // asynchronous reset during RESP
        txn(1'b0, 32'h10, 32'h0, lat);
        tick();
        check("rst_resp_pre", {31'h0, a_resp}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_resp",  {31'h0, a_resp}, 32'h0);
        check("arst_ack",   {31'h0, a_ack},  32'h0);
        check("arst_rdata", a_rdata,         32'h0);
        check("arst_cnt",   {16'h0, a_cnt},  32'h0);
        $display("async reset asserted during RESP");
        @(negedge clk);
        reset_n = 1'b1;
        txn(1'b0, 32'h10, 32'h0, lat);
        check("retain_lat", lat, 4);
        tick();
        check("retain_rdata", a_rdata, 32'hAAAA);
        tick();
        check("retain_cnt", {16'h0, a_cnt}, 32'd1);

        // random wait states: 100 held back-to-back writes
        lf = 8'h5A; prev_ack = -1; edge_n = 0; acks = 0; resp_seen = 0;
        b_req = 1'b1;
        while (acks < 100 && edge_n < 2000) begin
            tick();
            edge_n++;
            if (b_resp === 1'b1) resp_seen++;
            if (b_ack === 1'b1) begin
                w = lf[3:0] & 4'h3;
                check("rand_gap", edge_n - prev_ack, {28'h0, w} + 32'd3);
                $display("rand write %0d wait=%0d ack_edge=%0d", acks + 1, edge_n - prev_ack - 3, edge_n);
                prev_ack = edge_n;
                lf = lfsr_step(lf);
                acks++;
                if (acks == 100) b_req = 1'b0;
            end
        end
        check("rand_acks", acks, 100);
        tick();
        check("rand_ack_low", {31'h0, b_ack},  32'h0);
        check("rand_cnt",     {16'h0, b_cnt},  32'd100);
        check("rand_no_resp", resp_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
